fetch_queue: RTL and testbench

Instruction queue between the fetch stage and decode. It captures each fetched instruction/PC pair when fetch pulses its valid, buffers up to DEPTH entries, and presents them in order to decode over a valid/ready handshake. It reserves a slot for every outstanding fetch request, so a response is never dropped for lack of space. On a redirect it flushes and discards the stale in-flight response.

---
 rtl/fetch_queue.sv | 72 +++++++
 tb/tb_fetch_queue.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction/PC buffer between fetch and decode.
// Reserves a slot per outstanding fetch request and discards stale responses after a redirect.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_issue,
    input  logic        in_valid,
    input  logic [31:0] in_inst,
    input  logic [63:0] in_pc,
    output logic        fetch_en,
    input  logic        flush,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [63:0] out_pc,
    input  logic        out_ready,
    output logic        overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    logic [95:0]   mem [DEPTH];
    logic [AW-1:0] rptr, wptr;
    logic [AW:0]   count;
    logic          pend, drop;
    logic          pop, push;

    always_comb begin
        out_valid = count != '0;
        pop       = out_valid && out_ready;
        // at full, a same-cycle pop frees the slot being written
        push      = in_valid && !drop && (count != FULL || pop);
        fetch_en  = ({1'b0, count} + {{(AW + 1){1'b0}}, pend}) < {1'b0, FULL};
        out_inst  = out_valid ? mem[rptr][95:64] : '0;
        out_pc    = out_valid ? mem[rptr][63:0] : '0;
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wptr] <= {in_inst, in_pc};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
            pend     <= 1'b0;
            drop     <= 1'b0;
            overflow <= 1'b0;
        end else if (flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
            pend  <= req_issue || (pend && !in_valid);
            drop  <= !req_issue && !in_valid && pend;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            pend     <= req_issue || (pend && !in_valid);
            drop     <= drop && !in_valid;
            overflow <= overflow || (in_valid && !drop && !push);
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random checks of fetch_queue against a queue-based reference model.
module tb_fetch_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_issue = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_inst = '0;
    logic [63:0] in_pc = '0;
    logic        fetch_en;
    logic        flush = 1'b0;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [63:0] out_pc;
    logic        out_ready = 1'b0;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    logic [95:0] q[$];
    bit m_pend, m_drop, m_ovf;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .req_issue(req_issue), .in_valid(in_valid),
        .in_inst(in_inst), .in_pc(in_pc), .fetch_en(fetch_en), .flush(flush),
        .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
        .out_ready(out_ready), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] exp_flags();
        return {q.size() != 0, (q.size() + int'(m_pend)) < DEPTH, m_ovf};
    endfunction

    task automatic model_reset();
        q.delete();
        m_pend = 0;
        m_drop = 0;
        m_ovf = 0;
    endtask

    // advance one edge, applying the queue's rules to the inputs seen at that edge
    task automatic tick();
        bit pop, acc;
        @(posedge clk);
        pop = q.size() != 0 && out_ready;
        acc = in_valid && !m_drop && (q.size() < DEPTH || pop);
        if (flush) begin
            q.delete();
            if (req_issue) begin
                m_pend = 1;
                m_drop = 0;
            end else if (in_valid) begin
                m_pend = 0;
                m_drop = 0;
            end else if (m_pend) begin
                m_drop = 1;
            end
        end else begin
            if (in_valid && !m_drop && !acc)
                m_ovf = 1;
            if (in_valid)
                m_drop = 0;
            if (pop)
                void'(q.pop_front());
            if (acc)
                q.push_back({in_inst, in_pc});
            if (req_issue)
                m_pend = 1;
            else if (in_valid)
                m_pend = 0;
        end
        #1;
    endtask

    task automatic drive(input logic r, input logic v, input logic f, input logic rd, input logic [63:0] pc);
        req_issue = r;
        in_valid = v;
        flush = f;
        out_ready = rd;
        in_pc = pc;
        in_inst = $urandom;
        tick();
        req_issue = 0;
        in_valid = 0;
        flush = 0;
    endtask

    task automatic fill(input int n, input logic [63:0] base);
        for (int i = 0; i < n; i++) begin
            drive(1, 0, 0, 0, 0);
            drive(0, 1, 0, 0, base + 64'(4 * i));
        end
    endtask

    task automatic test_reset();
        rst = 0;
        #12;
        checks++;
        if ({out_valid, fetch_en, overflow, out_inst, out_pc} !== {3'b010, 96'h0}) begin
            errors++;
            $display("FAIL reset_state: got v/en/ovf=%b inst=%h pc=%h, want 010 and zeros",
                     {out_valid, fetch_en, overflow}, out_inst, out_pc);
        end
        @(negedge clk);
        rst = 1;
        model_reset();
        tick();
        checks++;
        if ({out_valid, fetch_en, overflow} !== exp_flags()) begin
            errors++;
            $display("FAIL reset_release: got %b want %b", {out_valid, fetch_en, overflow}, exp_flags());
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 0);
            if (i == 3) begin
                checks++;
                if (fetch_en !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_fetch_en_low: got %b want 0", fetch_en);
                end
            end
            drive(0, 1, 0, 0, 64'h8000_0000 + 64'(4 * i));
        end
        checks++;
        if ({out_valid, fetch_en, overflow} !== exp_flags() || out_pc !== 64'h8000_0000) begin
            errors++;
            $display("FAIL fill_full: got flags=%b pc=%h want %b pc=80000000",
                     {out_valid, fetch_en, overflow}, out_pc, exp_flags());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 64'h8000_0000 + 64'(4 * i)) begin
                errors++;
                $display("FAIL drain_order[%0d]: got v=%b pc=%h want pc=%h", i, out_valid, out_pc,
                         64'h8000_0000 + 64'(4 * i));
            end
            drive(0, 0, 0, 1, 0);
            if (i == 0) begin
                checks++;
                if (fetch_en !== 1'b1) begin
                    errors++;
                    $display("FAIL drain_fetch_en_high: got %b want 1", fetch_en);
                end
            end
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_concurrent();
        logic [63:0] want [4];
        want = '{64'h104, 64'h108, 64'h10C, 64'h200};
        fill(4, 64'h100);
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 1, 64'h200);
        checks++;
        if ({out_valid, overflow} !== 2'b10 || q.size() != 4 || out_pc !== 64'h104) begin
            errors++;
            $display("FAIL concurrent_full: got v=%b ovf=%b pc=%h want v=1 ovf=0 pc=104",
                     out_valid, overflow, out_pc);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== want[i]) begin
                errors++;
                $display("FAIL concurrent_order[%0d]: got v=%b pc=%h want %h", i, out_valid, out_pc, want[i]);
            end
            drive(0, 0, 0, 1, 0);
        end
    endtask

    task automatic test_flush_pending();
        fill(2, 64'h300);
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        checks++;
        if ({out_valid, fetch_en} !== 2'b01) begin
            errors++;
            $display("FAIL flush_pend_state: got v/en=%b want 01", {out_valid, fetch_en});
        end
        drive(0, 1, 0, 0, 64'h8000_0010);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_stale_dropped: got out_valid=%b want 0", out_valid);
        end
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 64'h8000_1000);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'h8000_1000) begin
            errors++;
            $display("FAIL flush_new_head: got v=%b pc=%h want v=1 pc=80001000", out_valid, out_pc);
        end
        drive(0, 0, 0, 1, 0);
    endtask

    task automatic test_flush_coincident();
        fill(1, 64'h3F0);
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 64'h400);
        checks++;
        if ({out_valid, fetch_en} !== 2'b01) begin
            errors++;
            $display("FAIL flush_inval_state: got v/en=%b want 01", {out_valid, fetch_en});
        end
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 64'h404);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'h404) begin
            errors++;
            $display("FAIL flush_inval_next_kept: got v=%b pc=%h want v=1 pc=404", out_valid, out_pc);
        end
        drive(0, 0, 0, 1, 0);
        fill(1, 64'h3E0);
        drive(1, 0, 1, 0, 0);
        checks++;
        if ({out_valid, fetch_en} !== 2'b01) begin
            errors++;
            $display("FAIL flush_req_state: got v/en=%b want 01", {out_valid, fetch_en});
        end
        drive(0, 1, 0, 0, 64'h408);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'h408) begin
            errors++;
            $display("FAIL flush_req_next_kept: got v=%b pc=%h want v=1 pc=408", out_valid, out_pc);
        end
        drive(0, 0, 0, 1, 0);
    endtask

    task automatic test_overflow();
        fill(4, 64'h500);
        drive(0, 1, 0, 0, 64'h5FF);
        checks++;
        if (overflow !== 1'b1 || out_pc !== 64'h500) begin
            errors++;
            $display("FAIL overflow_set: got ovf=%b pc=%h want ovf=1 pc=500", overflow, out_pc);
        end
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        fill(1, 64'h520);
        checks++;
        if (overflow !== 1'b1 || out_pc !== 64'h508) begin
            errors++;
            $display("FAIL overflow_sticky: got ovf=%b pc=%h want ovf=1 pc=508", overflow, out_pc);
        end
        #2;
        rst = 0;
        #1;
        model_reset();
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_reset: got %b want 0", overflow);
        end
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_async_reset();
        fill(3, 64'h600);
        drive(1, 0, 0, 0, 0);
        #2;
        rst = 0;
        #1;
        model_reset();
        checks++;
        if ({out_valid, fetch_en, overflow} !== 3'b010) begin
            errors++;
            $display("FAIL async_reset: got v/en/ovf=%b want 010", {out_valid, fetch_en, overflow});
        end
        @(negedge clk);
        rst = 1;
        drive(0, 1, 0, 0, 64'h700);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'h700 || fetch_en !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_push: got v=%b pc=%h en=%b want v=1 pc=700 en=1", out_valid, out_pc, fetch_en);
        end
        drive(0, 0, 0, 1, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (q.size() != 0) begin
                checks++;
                if ({out_inst, out_pc} !== q[0]) begin
                    errors++;
                    $display("FAIL random_head[%0d]: got %h_%h want %h", i, out_inst, out_pc, q[0]);
                end
            end
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 1) == 1, {$urandom, $urandom});
            checks++;
            if ({out_valid, fetch_en, overflow} !== exp_flags()) begin
                errors++;
                $display("FAIL random_flags[%0d]: got %b want %b", i, {out_valid, fetch_en, overflow}, exp_flags());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_concurrent();
        test_flush_pending();
        test_flush_coincident();
        test_overflow();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
